// File: rtl/fifo_rd_packer.sv
// Pops 16-bit words from the upstream synchronous FIFO and packs word pairs into 32-bit beats.
// A lone trailing word is flushed as a partial beat after an idle timeout. Define RD_PACKER_PARITY_EN to add out_par.
module fifo_rd_packer #(
    parameter int IN_WIDTH      = 16,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [IN_WIDTH-1:0]   fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [2*IN_WIDTH-1:0] out_data,
    output logic [1:0]            out_keep,
    output logic                  out_valid,
`ifdef RD_PACKER_PARITY_EN
    input  logic                  out_ready,
    output logic [1:0]            out_par
`else
    input  logic                  out_ready
`endif
);

    localparam int CW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT = CW'(FLUSH_TIMEOUT);

    logic                inflight;
    logic                lo_vld;
    logic [IN_WIDTH-1:0] lo_q;
    logic [CW-1:0]       idle_cnt;
    logic [1:0]          cnt;
    logic                out_free;
    logic                load_full;
    logic                idle_inc;
    logic                flush;

    assign cnt       = {1'b0, lo_vld} + {1'b0, inflight};
    assign out_free  = !out_valid || out_ready;
    assign load_full = inflight && lo_vld;

    // A read is issued only when its word is guaranteed a slot on arrival, so no skid buffer is needed.
    assign fifo_rd_en = rst_n && !fifo_empty &&
                        ((cnt == 2'd0) || ((cnt == 2'd1) && out_free));

    assign idle_inc = lo_vld && !inflight && !fifo_rd_en;
    assign flush    = (FLUSH_TIMEOUT != 0) && idle_inc && (idle_cnt == TIMEOUT) && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            lo_vld   <= 1'b0;
            lo_q     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight && !lo_vld) begin
                lo_q   <= fifo_data_out;
                lo_vld <= 1'b1;
            end else if (load_full || flush) begin
                lo_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (flush || !idle_inc) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // A freshly loaded beat replaces one leaving on the same edge; otherwise the beat holds until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= 2'b00;
        end else if (load_full) begin
            out_valid <= 1'b1;
            out_data  <= {fifo_data_out, lo_q};
            out_keep  <= 2'b11;
        end else if (flush) begin
            out_valid <= 1'b1;
            out_data  <= {{IN_WIDTH{1'b0}}, lo_q};
            out_keep  <= 2'b01;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RD_PACKER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 2'b00;
        end else if (load_full) begin
            out_par <= {^fifo_data_out, ^lo_q};
        end else if (flush) begin
            out_par <= {1'b0, ^lo_q};
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer with a behavioural one-cycle-latency FIFO upstream.
module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic [1:0]  out_keep;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_par_w;

    int vectors = 0;
    int miscompares = 0;

`ifdef RD_PACKER_PARITY_EN
    logic [1:0] out_par;
    assign out_par_w = out_par;
`else
    assign out_par_w = 2'b00;
`endif

    fifo_rd_packer #(.IN_WIDTH(16), .FLUSH_TIMEOUT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_valid     (out_valid),
`ifdef RD_PACKER_PARITY_EN
        .out_ready     (out_ready),
        .out_par       (out_par)
`else
        .out_ready     (out_ready)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO: words appear on data_out the cycle after a pop; reset empties it.
    logic [15:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= wr_ptr;
            fifo_data_out <= '0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Output monitor: logs every handshaken beat, underflow attempts and stalled-data changes.
    logic [35:0] beat_mem [0:63];
    int          beat_wr = 0;
    int          stall_err = 0;
    int          underflow_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en && fifo_empty) underflow_cnt++;
            if (prev_stall && out_data !== prev_data) stall_err++;
            if (out_valid && out_ready) begin
                beat_mem[beat_wr] = {out_par_w, out_keep, out_data};
                beat_wr++;
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_data  = out_data;
    end

    int beat_rd = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        mem[wr_ptr] = word;
        wr_ptr++;
    endtask

    task automatic nextCycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic expectBeat(input string tag, input logic [31:0] d, input logic [1:0] k);
        int n = 0;
        while (beat_wr <= beat_rd && n < 40) begin
            sampleCycle();
            n++;
        end
        if (beat_wr > beat_rd) begin
            checkOutput({tag, ".data"}, beat_mem[beat_rd][31:0], d);
            checkOutput({tag, ".keep"}, beat_mem[beat_rd][33:32], k);
`ifdef RD_PACKER_PARITY_EN
            checkOutput({tag, ".par"}, beat_mem[beat_rd][35:34], {^d[31:16], ^d[15:0]});
`endif
            beat_rd++;
        end else begin
            checkOutput({tag, ".arrived"}, beat_wr, beat_rd + 1);
        end
    endtask

    logic [31:0] bp_exp [0:3];

    initial begin
        int n;
        bp_exp[0] = 32'hB001_B000;
        bp_exp[1] = 32'hB003_B002;
        bp_exp[2] = 32'hB005_B004;
        bp_exp[3] = 32'hB007_B006;

        // Reset held with a word waiting in the FIFO.
        out_ready = 1'b1;
        nextCycle(2);
        applyStimulus(16'h5555);
        #1;
        checkOutput("rst.rd_en", fifo_rd_en, 1'b0);
        sampleCycle();
        checkOutput("rst.valid", out_valid, 1'b0);
        checkOutput("rst.data", out_data, 32'h0);
        checkOutput("rst.keep", out_keep, 2'b00);
        checkOutput("rst.par", out_par_w, 2'b00);
        nextCycle(2);
        rst_n = 1'b1;
        nextCycle(2);

        // Basic pack and first-beat latency.
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        sampleCycle();
        checkOutput("basic.rd_en", fifo_rd_en, 1'b1);
        n = 0;
        while (!out_valid && n < 30) begin
            sampleCycle();
            n++;
        end
        checkOutput("basic.latency", n, 3);
        expectBeat("basic", 32'h2222_1111, 2'b11);
        nextCycle(3);

        // Lone word flushed as a partial beat.
        applyStimulus(16'hABCD);
        sampleCycle();
        n = 0;
        while (!out_valid && n < 40) begin
            sampleCycle();
            n++;
        end
        checkOutput("flush.latency", n, 18);
        expectBeat("flush", 32'h0000_ABCD, 2'b01);
        nextCycle(3);

        // Partner word arrives before the timeout.
        applyStimulus(16'h0001);
        nextCycle(6);
        applyStimulus(16'h0002);
        expectBeat("late", 32'h0002_0001, 2'b11);
        nextCycle(25);
        checkOutput("late.no_partial", beat_wr, beat_rd);

        // Eight words under toggling backpressure.
        for (int i = 0; i < 8; i++) applyStimulus(16'hB000 + 16'(i));
        for (int i = 0; i < 40; i++) begin
            out_ready = ((i / 2) % 2) == 1;
            nextCycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) expectBeat($sformatf("bp%0d", i), bp_exp[i], 2'b11);
        nextCycle(20);
        checkOutput("bp.count", beat_wr, beat_rd);
        checkOutput("bp.stall_hold", stall_err, 0);

        // Read resumes in the same cycle the stall releases.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(16'hC000 + 16'(i));
        nextCycle(12);
        sampleCycle();
        checkOutput("stall.valid", out_valid, 1'b1);
        checkOutput("stall.data", out_data, 32'hC002_C001);
        checkOutput("stall.rd_en", fifo_rd_en, 1'b0);
        nextCycle();
        out_ready = 1'b1;
        #1;
        checkOutput("stall.release", fifo_rd_en, 1'b1);
        expectBeat("stall0", 32'hC002_C001, 2'b11);
        expectBeat("stall1", 32'hC004_C003, 2'b11);
        nextCycle(5);

        // Reset while a low half is held and a read is in flight.
        applyStimulus(16'hD001);
        applyStimulus(16'hD002);
        applyStimulus(16'hD003);
        nextCycle(2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid.rd_en", fifo_rd_en, 1'b0);
        sampleCycle();
        checkOutput("mid.valid", out_valid, 1'b0);
        checkOutput("mid.data", out_data, 32'h0);
        checkOutput("mid.keep", out_keep, 2'b00);
        checkOutput("mid.par", out_par_w, 2'b00);
        nextCycle(2);
        rst_n = 1'b1;
        nextCycle(2);
        checkOutput("mid.no_stale", beat_wr, beat_rd);
        applyStimulus(16'h1357);
        applyStimulus(16'h0001);
        expectBeat("mid", 32'h0001_1357, 2'b11);
        nextCycle(25);
        checkOutput("mid.count", beat_wr, beat_rd);

        checkOutput("underflow", underflow_cnt, 0);
        checkOutput("stall_hold", stall_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer that sits directly downstream of the synchronous FIFO (16-bit words). It pops words through the FIFO's `rd_en`/`empty`/`data_out` interface, accounting for the FIFO's one-cycle read latency. It packs consecutive word pairs into 32-bit beats on a valid/ready output stream. A lone trailing word is flushed as a partial beat after a configurable idle timeout.

## Interface
- `IN_WIDTH`, 16: FIFO word width. Must equal the FIFO's `FIFO_WIDTH`.
- `FLUSH_TIMEOUT`, 15: idle cycles before a lone low half is emitted as a partial beat. 0 disables flushing.
- `clk`  in  1  single clock shared with the FIFO.
- `rst_n`  in  1  asynchronous, active-low reset. Same net as the FIFO's `rst_n`.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data_out`  in  IN_WIDTH  FIFO `data_out`. Valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `out_data`  out  2*IN_WIDTH  packed beat. First-popped word in `[IN_WIDTH-1:0]`.
- `out_keep`  out  2  half-valid mask: `2'b11` for a full beat, `2'b01` for a partial beat.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_par`  out  2  even parity per half. Present only with `RD_PACKER_PARITY_EN`.

## Operation
- **State:**
  - `inflight`: a read was issued last cycle.
  - `lo_vld`/`lo_q`: held low half.
  - Output register `out_valid`/`out_data`/`out_keep`.
  - Idle counter `idle_cnt`, width `$clog2(FLUSH_TIMEOUT+1)`, minimum 1.
- **Occupancy:** `cnt = lo_vld + inflight` (0..2).
- **Read issue (combinational):** `fifo_rd_en = rst_n & !fifo_empty & (cnt==0 | (cnt==1 & (!out_valid | out_ready)))`.
  - A read is never issued when its arrival could not be stored, so no data is dropped and no extra buffering is needed.
  - Sustained throughput is 2 words per 3 cycles.
- **Arrival:** when `inflight`, capture `fifo_data_out` on the edge.
  - If `!lo_vld`, load it into `lo_q` and set `lo_vld`.
  - Otherwise, load the output register with `{fifo_data_out, lo_q}`, `keep=2'b11`, `out_valid=1`, and clear `lo_vld`.
- **Output handshake:**
  - A beat transfers on an edge where `out_valid & out_ready`.
  - `out_valid` clears unless a new beat is loaded on that same edge.
  - `out_data`/`out_keep` hold while `out_valid & !out_ready`.
- **Flush:** `idle_cnt` increments each cycle that `lo_vld & !inflight & !fifo_rd_en`, saturating at `FLUSH_TIMEOUT`; it clears otherwise.
  - When `idle_cnt==FLUSH_TIMEOUT` (nonzero) and the output is free (`!out_valid | out_ready`), load the output register with `{0, lo_q}`, `keep=2'b01`, and clear `lo_vld` and `idle_cnt`.
  - A read issued in the same cycle wins; no flush happens.
- **Reset mid-operation:** any in-flight read and held half are discarded. The FIFO resets on the same net, so both sides restart empty.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_keep=2'b00`, `out_par=2'b00`, `fifo_rd_en=0`, `lo_vld=0`, `inflight=0`, `idle_cnt=0`.
- **Read latency:** `fifo_rd_en` high in cycle t means data is present on `fifo_data_out` in t+1 and captured at the end of t+1.
- **First-beat latency:** with reads in t and t+1, `out_valid` rises in t+3.
- **Stall release:** with `cnt==1` and the output stalled, `fifo_rd_en` re-asserts in the same cycle that `out_ready` rises.
- **Empty handling:** `fifo_rd_en` is low whenever `fifo_empty` is high, so the FIFO's underflow flag never asserts.

## Configuration
- **`RD_PACKER_PARITY_EN` defined:**
  - `out_par[0]` is the XOR of `out_data[IN_WIDTH-1:0]`; `out_par[1]` is the XOR of the high half. Parity of a zero-filled half is 0.
  - Parity is registered with `out_data`.
- **Undefined:** the `out_par` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n=0` with FIFO non-empty -> `fifo_rd_en=0`, `out_valid=0`, `out_data=0`.
- **Basic pack:** FIFO holds `16'h1111`, `16'h2222`, `out_ready=1` -> one beat `32'h2222_1111`, `keep=2'b11`, `out_valid` 3 cycles after the first `fifo_rd_en`.
- **Backpressure:** 8 words streamed with `out_ready` toggling every 2 cycles -> 4 beats in order, no duplicates or drops, FIFO underflow never asserted, `out_data` stable while stalled.
- **Flush:** single word `16'hABCD`, `FLUSH_TIMEOUT=15` -> partial beat `32'h0000_ABCD`, `keep=2'b01`, appears 15 idle cycles after capture.
- **Late partner:** word `16'h0001`, then word `16'h0002` written before the timeout -> one full beat `32'h0002_0001`, no partial beat.
- **Reset mid-beat:** reset asserted with `lo_vld=1` and a read in flight -> after release, the next two words pack cleanly. With `RD_PACKER_PARITY_EN` defined, `out_par` matches per-half XOR.
